vip_filter_frame_ctrl: RTL and testbench
========================================

VIP_FILTER_FRAME_CTRL -- requirements
Module: vip_filter_frame_ctrl

Interface
REQ-001 SHALL have parameter IMG_HDISP, default 640, active pixels per line.
REQ-002 SHALL have parameter IMG_VDISP, default 480, active lines per frame.
REQ-003 SHALL have parameter PIPE_LAT, default 4, downstream filter pipeline latency in clocks; legal range 1..15.
REQ-004 SHALL have ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- per_frame_vsync  in  1  frame valid; high for the whole frame.
- per_frame_href  in  1  line valid.
- per_frame_clken  in  1  pixel strobe.
- cfg_filt_en  in  1  requested filter enable; 1 = median, 0 = bypass.
- cfg_req  in  1  one-cycle request to apply cfg_filt_en.
- filt_en  out  1  active filter select to the datapath; stable within a frame.
- cfg_ack  out  1  one-cycle pulse when a pending config is applied.
- border_flag  out  1  pixel of the previous cycle lies on the image border.
- pix_strobe_d  out  1  per_frame_clken AND per_frame_href delayed 1 clock; qualifies border_flag.
- hcnt  out  11  current column count.
- vcnt  out  10  current line count.
- busy  out  1  high in ACTIVE or DRAIN.
- frame_done  out  1  one-cycle pulse when a frame has fully left the pipeline.
- line_err  out  1  one-cycle pulse on a short or long line.
- frame_err  out  1  one-cycle pulse on a wrong line count.

Function
REQ-005 SHALL implement FSM states IDLE, ACTIVE, DRAIN.
REQ-006 SHALL detect vsync rise as registered vsync=0 and input=1, and vsync fall as the inverse.
REQ-007 IDLE -> ACTIVE on vsync rise; in the same cycle, hcnt and vcnt SHALL clear to 0.
REQ-008 ACTIVE -> DRAIN on vsync fall; the drain counter SHALL load PIPE_LAT.
REQ-009 DRAIN SHALL decrement the drain counter each clock.
- At 0: frame_done SHALL pulse for 1 cycle and the FSM SHALL go to IDLE.
- A vsync rise during DRAIN SHALL go straight to ACTIVE (back-to-back frames), SHALL still pulse frame_done that cycle, and SHALL clear the counters.
REQ-010 In ACTIVE, each cycle with href=1 and clken=1 SHALL increment hcnt; hcnt SHALL saturate at 2047.
REQ-011 On href fall in ACTIVE:
- line_err SHALL pulse if hcnt != IMG_HDISP.
- vcnt SHALL increment, saturating at 1023.
- hcnt SHALL clear.
REQ-012 On vsync fall, frame_err SHALL pulse if vcnt != IMG_VDISP, counting a line still open (href=1) at the fall as completed.
REQ-013 If href and vsync fall in the same cycle, the line-end actions (REQ-011) SHALL be evaluated before the frame check (REQ-012).
REQ-014 border_flag SHALL be registered; it SHALL be 1 when the accepted pixel has hcnt==0 or hcnt==IMG_HDISP-1 or vcnt==0 or vcnt==IMG_VDISP-1, and 0 when no pixel is accepted.
REQ-015 cfg_req SHALL set a pending flag and capture cfg_filt_en; a later cfg_req before apply SHALL overwrite the captured value (last wins).
REQ-016 A pending config SHALL be applied to filt_en:
- on the next vsync rise, or
- immediately in IDLE when no vsync rise occurs that cycle.
On apply, cfg_ack SHALL pulse and pending SHALL clear.
REQ-017 cfg_req coincident with a vsync rise SHALL be applied at that rise.
REQ-018 filt_en SHALL never change in ACTIVE or DRAIN.
REQ-019 Pixels or href while in IDLE SHALL be ignored: no count, no error.

Reset
REQ-020 On rst=1 at a clock edge, the block SHALL set:
- FSM = IDLE, pending = 0.
- filt_en = 1.
- hcnt = 0, vcnt = 0.
- all pulses, border_flag, pix_strobe_d and busy = 0.
- registered vsync = 0.
REQ-021 Reset mid-frame SHALL abort without frame_done or frame_err; if vsync is still high on release, the first vsync rise after release SHALL be the next frame start.

Verification
REQ-022 4x3 frame (IMG_HDISP=4, IMG_VDISP=3), PIPE_LAT=4, clean timing -> border_flag=1 for all pixels except (1,1),(2,1); no errors; frame_done exactly 5 clocks after vsync fall.
REQ-023 Line 1 carries 3 pixels -> line_err pulse at that href fall; vcnt still increments; frame_err=0.
REQ-024 cfg_req with filt_en=0 mid-frame -> filt_en stays 1 until the next vsync rise, then 0 with cfg_ack in the same cycle; two cfg_req (0 then 1) mid-frame -> filt_en=1 applied.
REQ-025 Second vsync rise 2 clocks after vsync fall -> frame_done pulses at that rise; FSM ACTIVE; counters 0.
REQ-026 rst asserted at line 1 pixel 2 -> all outputs 0 and filt_en=1 next cycle; no frame_done; the next full frame passes cleanly.
REQ-027 Frame with 2 lines -> frame_err pulse at vsync fall; href and vsync falling together on the last line -> no frame_err at IMG_VDISP lines.

Source files
------------

// File: rtl/vip_filter_frame_ctrl.sv
// Frame controller for the video filter path: tracks frame/line timing,
// counts pixels and lines, flags border pixels, reports timing errors,
// waits for the filter pipeline to drain after each frame, and applies
// filter-enable changes only between frames.
//
// state  | meaning
// IDLE   | no frame in progress; pending config is applied immediately
// ACTIVE | inside a frame (vsync high); pixels and lines are counted
// DRAIN  | vsync has fallen; waiting PIPE_LAT clocks for the pipeline to empty
module vip_filter_frame_ctrl #(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int PIPE_LAT  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic        cfg_filt_en,
  input  logic        cfg_req,
  output logic        filt_en,
  output logic        cfg_ack,
  output logic        border_flag,
  output logic        pix_strobe_d,
  output logic [10:0] hcnt,
  output logic [9:0]  vcnt,
  output logic        busy,
  output logic        frame_done,
  output logic        line_err,
  output logic        frame_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  localparam logic [10:0] H_DISP     = 11'(IMG_HDISP);
  localparam logic [10:0] H_LAST     = 11'(IMG_HDISP - 1);
  localparam logic [9:0]  V_DISP     = 10'(IMG_VDISP);
  localparam logic [9:0]  V_LAST     = 10'(IMG_VDISP - 1);
  localparam logic [3:0]  DRAIN_LOAD = 4'(PIPE_LAT);
  localparam logic [10:0] H_MAX      = 11'h7FF;
  localparam logic [9:0]  V_MAX      = 10'h3FF;

  state_e      state_q, state_d;
  logic        vsync_q, href_q, armed_q;
  logic [10:0] hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic [3:0]  drain_q, drain_d;
  logic        pend_q, pend_d;
  logic        pval_q, pval_d;
  logic        filt_q, filt_d;
  logic        ack_q, ack_d;
  logic        done_q, done_d;
  logic        lerr_q, lerr_d;
  logic        ferr_q, ferr_d;
  logic        border_q, border_d;
  logic        strobe_q;

  logic        vsync_rise, vsync_fall, href_fall, pix_acc, apply;
  logic [9:0]  vcnt_inc, vcnt_frame;

  // armed_q blocks a false frame start when reset releases with vsync already high
  assign vsync_rise = armed_q & ~vsync_q & per_frame_vsync;
  assign vsync_fall = vsync_q & ~per_frame_vsync;
  assign href_fall  = href_q & ~per_frame_href;
  assign pix_acc    = (state_q == ST_ACTIVE) & per_frame_href & per_frame_clken;
  assign vcnt_inc   = (vcnt_q == V_MAX) ? vcnt_q : vcnt_q + 10'd1;
  // a line ending or still open at vsync fall counts toward the frame check
  assign vcnt_frame = (href_fall | per_frame_href) ? vcnt_inc : vcnt_q;

  // next-state, counter and pulse logic
  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;
    drain_d  = drain_q;
    done_d   = 1'b0;
    lerr_d   = 1'b0;
    ferr_d   = 1'b0;
    border_d = 1'b0;
    ack_d    = 1'b0;
    filt_d   = filt_q;
    pend_d   = pend_q | cfg_req;
    pval_d   = cfg_req ? cfg_filt_en : pval_q;
    apply    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (vsync_rise) begin
          state_d = ST_ACTIVE;
          hcnt_d  = '0;
          vcnt_d  = '0;
        end
      end
      ST_ACTIVE: begin
        if (pix_acc) begin
          border_d = (hcnt_q == 11'd0) | (hcnt_q == H_LAST) |
                     (vcnt_q == 10'd0) | (vcnt_q == V_LAST);
          if (hcnt_q != H_MAX) hcnt_d = hcnt_q + 11'd1;
        end
        if (href_fall) begin
          lerr_d = (hcnt_q != H_DISP);
          vcnt_d = vcnt_inc;
          hcnt_d = '0;
        end
        if (vsync_fall) begin
          ferr_d  = (vcnt_frame != V_DISP);
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (vsync_rise) begin
          done_d  = 1'b1;
          state_d = ST_ACTIVE;
          hcnt_d  = '0;
          vcnt_d  = '0;
        end else if (drain_q == 4'd0) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // filter select only moves at a frame start or while idle
    apply = pend_d & (state_q != ST_ACTIVE) & (vsync_rise | (state_q == ST_IDLE));
    if (apply) begin
      filt_d = pval_d;
      ack_d  = 1'b1;
      pend_d = 1'b0;
    end
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      vsync_q  <= 1'b0;
      href_q   <= 1'b0;
      armed_q  <= ~per_frame_vsync;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      drain_q  <= '0;
      pend_q   <= 1'b0;
      pval_q   <= 1'b1;
      filt_q   <= 1'b1;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      lerr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      border_q <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      vsync_q  <= per_frame_vsync;
      href_q   <= per_frame_href;
      armed_q  <= armed_q | ~per_frame_vsync;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      drain_q  <= drain_d;
      pend_q   <= pend_d;
      pval_q   <= pval_d;
      filt_q   <= filt_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      lerr_q   <= lerr_d;
      ferr_q   <= ferr_d;
      border_q <= border_d;
      strobe_q <= per_frame_clken & per_frame_href;
    end
  end

  assign filt_en      = filt_q;
  assign cfg_ack      = ack_q;
  assign border_flag  = border_q;
  assign pix_strobe_d = strobe_q;
  assign hcnt         = hcnt_q;
  assign vcnt         = vcnt_q;
  assign busy         = (state_q != ST_IDLE);
  assign frame_done   = done_q;
  assign line_err     = lerr_q;
  assign frame_err    = ferr_q;

endmodule

// File: tb/tb_vip_filter_frame_ctrl.sv
// Directed bench for vip_filter_frame_ctrl on a 4x3 image with a 4-clock
// pipeline. Border expectations are queued as pixels are driven and popped
// when the delayed strobe appears.
module tb_vip_filter_frame_ctrl;

  localparam int HD = 4;
  localparam int VD = 3;
  localparam int PL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        per_frame_vsync = 1'b0;
  logic        per_frame_href  = 1'b0;
  logic        per_frame_clken = 1'b0;
  logic        cfg_filt_en     = 1'b0;
  logic        cfg_req         = 1'b0;
  logic        filt_en, cfg_ack, border_flag, pix_strobe_d, busy;
  logic        frame_done, line_err, frame_err;
  logic [10:0] hcnt;
  logic [9:0]  vcnt;

  int   n_vec = 0;
  int   n_err = 0;
  int   row_m = 0;
  int   col_m = 0;
  bit   in_frame_m = 1'b0;
  logic exp_filt_m = 1'b1;
  int   n_lerr = 0, n_ferr = 0, n_done = 0, n_ack = 0;
  int   base_l, base_f, base_d, base_a;
  logic sb_q[$];

  always #5 clk = ~clk;

  vip_filter_frame_ctrl #(
    .IMG_HDISP(HD),
    .IMG_VDISP(VD),
    .PIPE_LAT (PL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .per_frame_vsync(per_frame_vsync),
    .per_frame_href (per_frame_href),
    .per_frame_clken(per_frame_clken),
    .cfg_filt_en    (cfg_filt_en),
    .cfg_req        (cfg_req),
    .filt_en        (filt_en),
    .cfg_ack        (cfg_ack),
    .border_flag    (border_flag),
    .pix_strobe_d   (pix_strobe_d),
    .hcnt           (hcnt),
    .vcnt           (vcnt),
    .busy           (busy),
    .frame_done     (frame_done),
    .line_err       (line_err),
    .frame_err      (frame_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // one clock of stimulus; sample 1ns after the edge
  task automatic tick(input int vs, input int hr, input int ck, input int cr, input int cv);
    logic exp_b;
    per_frame_vsync = vs[0];
    per_frame_href  = hr[0];
    per_frame_clken = ck[0];
    cfg_req         = cr[0];
    cfg_filt_en     = cv[0];
    if (hr[0] && ck[0]) begin
      if (in_frame_m) begin
        exp_b = (col_m == 0) || (col_m == HD - 1) || (row_m == 0) || (row_m == VD - 1);
        col_m++;
      end else begin
        exp_b = 1'b0;
      end
      sb_q.push_back(exp_b);
    end
    @(posedge clk);
    #1;
    if (line_err)   n_lerr++;
    if (frame_err)  n_ferr++;
    if (frame_done) n_done++;
    if (cfg_ack)    n_ack++;
    if (pix_strobe_d) begin
      if (sb_q.size() == 0) begin
        chk("strobe_without_pixel", 32'(pix_strobe_d), 32'd0);
      end else begin
        exp_b = sb_q.pop_front();
        chk("border_flag", 32'(border_flag), 32'(exp_b));
      end
    end else begin
      chk("border_idle", 32'(border_flag), 32'd0);
    end
  endtask

  task automatic start_frame(input int cr, input int cv);
    tick(1, 0, 0, cr, cv);
    in_frame_m = 1'b1;
    row_m = 0;
    col_m = 0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_hcnt", 32'(hcnt), 32'd0);
    chk("start_vcnt", 32'(vcnt), 32'd0);
  endtask

  task automatic send_line(input int n, input int cr, input int cv);
    tick(1, 0, 0, cr, cv);
    col_m = 0;
    for (int i = 0; i < n; i++) tick(1, 1, 1, 0, 0);
    chk("hcnt_line", 32'(hcnt), 32'(n));
    tick(1, 0, 0, 0, 0);
    chk("line_err", 32'(line_err), 32'(n != HD));
    row_m++;
    chk("vcnt_line", 32'(vcnt), 32'(row_m));
    chk("hcnt_clear", 32'(hcnt), 32'd0);
    chk("filt_hold", 32'(filt_en), 32'(exp_filt_m));
  endtask

  task automatic end_frame(input int exp_ferr);
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    in_frame_m = 1'b0;
    chk("frame_err", 32'(frame_err), 32'(exp_ferr));
    chk("drain_busy", 32'(busy), 32'd1);
  endtask

  task automatic join_line(input int n, input int exp_ferr);
    tick(1, 0, 0, 0, 0);
    col_m = 0;
    for (int i = 0; i < n; i++) tick(1, 1, 1, 0, 0);
    tick(0, 0, 0, 0, 0);
    in_frame_m = 1'b0;
    chk("join_line_err", 32'(line_err), 32'(n != HD));
    chk("join_frame_err", 32'(frame_err), 32'(exp_ferr));
    chk("join_vcnt", 32'(vcnt), 32'(row_m + 1));
    row_m++;
  endtask

  task automatic wait_done();
    int lat;
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      tick(0, 0, 0, 0, 0);
      if (frame_done) begin
        lat = i;
        break;
      end
    end
    chk("done_latency", 32'(lat), 32'(PL + 1));
    chk("done_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_filt_en", 32'(filt_en), 32'd1);
    chk("rst_cfg_ack", 32'(cfg_ack), 32'd0);
    chk("rst_border", 32'(border_flag), 32'd0);
    chk("rst_strobe", 32'(pix_strobe_d), 32'd0);
    chk("rst_hcnt", 32'(hcnt), 32'd0);
    chk("rst_vcnt", 32'(vcnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_line_err", 32'(line_err), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    tick(0, 0, 0, 0, 0);

    // clean 4x3 frame
    base_l = n_lerr; base_f = n_ferr;
    start_frame(0, 0);
    send_line(4, 0, 0);
    send_line(4, 0, 0);
    send_line(4, 0, 0);
    end_frame(0);
    wait_done();
    chk("clean_line_errs", 32'(n_lerr - base_l), 32'd0);
    chk("clean_frame_errs", 32'(n_ferr - base_f), 32'd0);

    // short and long lines
    tick(0, 0, 0, 0, 0);
    base_l = n_lerr; base_f = n_ferr;
    start_frame(0, 0);
    send_line(4, 0, 0);
    send_line(3, 0, 0);
    send_line(5, 0, 0);
    end_frame(0);
    wait_done();
    chk("bad_line_errs", 32'(n_lerr - base_l), 32'd2);
    chk("bad_line_frame_errs", 32'(n_ferr - base_f), 32'd0);

    // pixels and href while idle are ignored
    base_l = n_lerr;
    tick(0, 1, 1, 0, 0);
    tick(0, 1, 1, 0, 0);
    tick(0, 1, 1, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    chk("idle_hcnt", 32'(hcnt), 32'd0);
    chk("idle_vcnt", 32'(vcnt), 32'(VD));
    chk("idle_line_errs", 32'(n_lerr - base_l), 32'd0);

    // config while idle applies at once
    tick(0, 0, 0, 1, 0);
    exp_filt_m = 1'b0;
    chk("idle_cfg_filt", 32'(filt_en), 32'd0);
    chk("idle_cfg_ack", 32'(cfg_ack), 32'd1);
    tick(0, 0, 0, 0, 0);
    chk("idle_cfg_ack_off", 32'(cfg_ack), 32'd0);

    // config coincident with frame start, then mid-frame request held off
    start_frame(1, 1);
    exp_filt_m = 1'b1;
    chk("rise_cfg_filt", 32'(filt_en), 32'd1);
    chk("rise_cfg_ack", 32'(cfg_ack), 32'd1);
    base_a = n_ack;
    send_line(4, 0, 0);
    send_line(4, 1, 0);
    send_line(4, 0, 0);
    end_frame(0);
    tick(0, 0, 0, 0, 0);
    chk("drain_filt_hold", 32'(filt_en), 32'd1);
    chk("mid_frame_no_ack", 32'(n_ack - base_a), 32'd0);

    // back-to-back frame: rise two clocks after the fall
    base_d = n_done;
    start_frame(0, 0);
    exp_filt_m = 1'b0;
    chk("b2b_done", 32'(frame_done), 32'd1);
    chk("b2b_filt", 32'(filt_en), 32'd0);
    chk("b2b_ack", 32'(cfg_ack), 32'd1);

    // two requests mid-frame, last one wins; frame has only 2 lines
    base_f = n_ferr;
    send_line(4, 1, 0);
    send_line(4, 1, 1);
    end_frame(1);
    wait_done();
    chk("b2b_done_count", 32'(n_done - base_d), 32'd2);
    chk("short_frame_errs", 32'(n_ferr - base_f), 32'd1);
    chk("done_filt_hold", 32'(filt_en), 32'd0);
    tick(0, 0, 0, 0, 0);
    exp_filt_m = 1'b1;
    chk("last_wins_filt", 32'(filt_en), 32'd1);
    chk("last_wins_ack", 32'(cfg_ack), 32'd1);

    // href and vsync fall together on the last line
    tick(0, 0, 0, 0, 0);
    base_l = n_lerr; base_f = n_ferr;
    start_frame(0, 0);
    send_line(4, 0, 0);
    send_line(4, 0, 0);
    join_line(4, 0);
    wait_done();
    chk("join_frame_errs", 32'(n_ferr - base_f), 32'd0);
    chk("join_line_errs", 32'(n_lerr - base_l), 32'd0);

    // reset in the middle of line 1
    tick(0, 0, 0, 1, 0);
    exp_filt_m = 1'b0;
    chk("pre_rst_filt", 32'(filt_en), 32'd0);
    tick(0, 0, 0, 0, 0);
    base_d = n_done; base_f = n_ferr;
    start_frame(0, 0);
    send_line(4, 0, 0);
    tick(1, 0, 0, 0, 0);
    col_m = 0;
    tick(1, 1, 1, 0, 0);
    rst = 1'b1;
    tick(1, 1, 1, 0, 0);
    rst = 1'b0;
    sb_q.delete();
    in_frame_m = 1'b0;
    exp_filt_m = 1'b1;
    chk("mid_rst_filt", 32'(filt_en), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_hcnt", 32'(hcnt), 32'd0);
    chk("mid_rst_vcnt", 32'(vcnt), 32'd0);
    chk("mid_rst_strobe", 32'(pix_strobe_d), 32'd0);
    chk("mid_rst_done", 32'(frame_done), 32'd0);
    chk("mid_rst_frame_err", 32'(frame_err), 32'd0);
    chk("mid_rst_ack", 32'(cfg_ack), 32'd0);
    tick(1, 1, 1, 0, 0);
    tick(1, 1, 1, 0, 0);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    chk("post_rst_no_start", 32'(busy), 32'd0);
    chk("post_rst_hcnt", 32'(hcnt), 32'd0);
    chk("post_rst_no_done", 32'(n_done - base_d), 32'd0);
    chk("post_rst_no_ferr", 32'(n_ferr - base_f), 32'd0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    base_l = n_lerr;
    start_frame(0, 0);
    send_line(4, 0, 0);
    send_line(4, 0, 0);
    send_line(4, 0, 0);
    end_frame(0);
    wait_done();
    chk("post_rst_line_errs", 32'(n_lerr - base_l), 32'd0);
    chk("post_rst_frame_errs", 32'(n_ferr - base_f), 32'd0);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
